// File: rtl/ysyx_22041211_mem_arbiter.sv
// ysyx_22041211_mem_arbiter: round-robin IFU/LSU arbiter onto one memory port with a response watchdog
module ysyx_22041211_mem_arbiter #(
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    input  logic [DATA_LEN-1:0] ifu_addr,
    output logic                ifu_req_ready,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    input  logic [DATA_LEN-1:0] lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [3:0]          lsu_wmask,
    output logic                lsu_req_ready,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [3:0]          mem_wmask,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata,
    input  logic                mem_resp_err
);
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10, RESP = 2'b11} state_t;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    state_t state, state_n;
    logic last_lsu, grant_lsu, err_q, hit, expired, done, grant;
    logic [WD_W-1:0] wd;
    logic [DATA_LEN-1:0] rdata_q;
    // ties go to whoever did not win last time
    assign ifu_req_ready = !rst && state == IDLE && ifu_req_valid && (!lsu_req_valid || last_lsu);
    assign lsu_req_ready = !rst && state == IDLE && lsu_req_valid && (!ifu_req_valid || !last_lsu);
    assign grant = ifu_req_ready || lsu_req_ready;
    assign hit = ((state == REQ && mem_req_ready) || state == WAIT) && mem_resp_valid;
    assign expired = wd == WD_W'(TIMEOUT - 1);
    assign done = (state == REQ || state == WAIT) && (hit || expired);
    assign mem_req_valid = state == REQ;
    assign ifu_resp_valid = state == RESP && !grant_lsu;
    assign lsu_resp_valid = state == RESP && grant_lsu;
    assign ifu_rdata = ifu_resp_valid ? rdata_q : '0;
    assign lsu_rdata = lsu_resp_valid ? rdata_q : '0;
    assign ifu_resp_err = ifu_resp_valid && err_q;
    assign lsu_resp_err = lsu_resp_valid && err_q;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = grant ? REQ : IDLE;
            REQ:     state_n = done ? RESP : mem_req_ready ? WAIT : REQ;
            WAIT:    state_n = done ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu  <= 1'b1;
            grant_lsu <= 1'b0;
            wd        <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            if (grant) begin
                grant_lsu <= lsu_req_ready;
                last_lsu  <= lsu_req_ready;
                mem_addr  <= lsu_req_ready ? lsu_addr : ifu_addr;
                mem_wen   <= lsu_req_ready && lsu_wen;
                mem_wdata <= lsu_req_ready ? lsu_wdata : '0;
                mem_wmask <= lsu_req_ready ? lsu_wmask : '0;
                wd        <= '0;
            end else if (state == REQ || state == WAIT) begin
                wd <= wd + WD_W'(1);
            end
            // a genuine response beats a simultaneous timeout
            if (done) begin
                rdata_q <= hit ? mem_rdata : '0;
                err_q   <= hit ? mem_resp_err : 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// tb_ysyx_22041211_mem_arbiter: directed scoreboard bench for the IFU/LSU memory arbiter
module tb_ysyx_22041211_mem_arbiter;
    localparam logic [31:0] K = 32'h5A5A_0000;
    typedef struct packed {logic lsu; logic [31:0] rdata; logic err;} exp_t;
    logic clk, rst;
    logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic lsu_req_valid, lsu_wen, lsu_req_ready, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0] lsu_wmask, mem_wmask;
    logic mem_req_valid, mem_wen, mem_req_ready, mem_resp_valid, mem_resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    int stall = 0, sc = 0;
    bit hang = 0, noresp = 0, stray = 0, fixed_en = 0, fixed_err = 0, pend = 0, perr = 0;
    logic [31:0] fixed_data = 0, pdata = 0;

    ysyx_22041211_mem_arbiter #(.DATA_LEN(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_addr(ifu_addr), .ifu_req_ready(ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_req_ready(lsu_req_ready),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'(|{ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_req_ready,
                       lsu_resp_valid, lsu_rdata, lsu_resp_err, mem_req_valid, mem_addr,
                       mem_wen, mem_wdata, mem_wmask}), 32'd0);
    endtask

    task automatic push(input logic lsu, input logic [31:0] d, input logic e);
        exp_t x;
        x.lsu = lsu; x.rdata = d; x.err = e;
        sb.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // slave model: optional ready stall, response one cycle after acceptance
    always @(posedge clk) begin
        #1;
        mem_resp_valid = pend || stray;
        mem_rdata = pend ? pdata : 32'h0;
        mem_resp_err = pend && perr;
        pend = 0;
        mem_req_ready = 0;
        if (rst) sc = 0;
        else if (mem_req_valid && !hang) begin
            if (sc < stall) sc++;
            else begin
                mem_req_ready = 1;
                sc = 0;
                pend = !noresp;
                pdata = fixed_en ? fixed_data : mem_wen ? 32'h0 : mem_addr ^ K;
                perr = fixed_en && fixed_err;
            end
        end
    end

    // scoreboard: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (ifu_resp_valid || lsu_resp_valid) begin
            chk("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("resp_who", {30'd0, ifu_resp_valid, lsu_resp_valid}, x.lsu ? 32'd1 : 32'd2);
                chk("resp_rdata", x.lsu ? lsu_rdata : ifu_rdata, x.rdata);
                chk("resp_err", 32'(x.lsu ? lsu_resp_err : ifu_resp_err), 32'(x.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int g, n;
        rst = 1; ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
        lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
        repeat (2) cyc();
        smp(); chk_quiet("reset_outputs");
        cyc(); rst = 0;
        // IFU-only read
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        fixed_en = 1; fixed_data = 32'h0000_0413; fixed_err = 0;
        push(0, 32'h0000_0413, 0);
        smp(); chk("t1_ifu_ready", 32'(ifu_req_ready), 1); chk("t1_lsu_ready", 32'(lsu_req_ready), 0);
        cyc(); ifu_req_valid = 0; ifu_addr = 0;
        smp(); chk("t1_mem_valid", 32'(mem_req_valid), 1); chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", 32'(mem_wen), 0); chk("t1_mem_wdata", mem_wdata, 0); chk("t1_mem_wmask", 32'(mem_wmask), 0);
        cyc(); smp(); chk("t1_mem_valid_low", 32'(mem_req_valid), 0); chk("t1_early_resp", 32'(ifu_resp_valid), 0);
        cyc(); smp(); chk("t1_resp", 32'(ifu_resp_valid), 1); chk("t1_lsu_quiet", 32'(lsu_resp_valid), 0);
        cyc(); smp(); chk("t1_pulse_end", 32'(ifu_resp_valid), 0); chk("t1_rdata_zero", ifu_rdata, 0);
        // LSU store
        cyc(); fixed_en = 0;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        push(1, 32'h0, 0);
        smp(); chk("t2_lsu_ready", 32'(lsu_req_ready), 1); chk("t2_ifu_ready", 32'(ifu_req_ready), 0);
        cyc(); lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        smp(); chk("t2_mem_valid", 32'(mem_req_valid), 1); chk("t2_mem_addr", mem_addr, 32'h8000_1000);
        chk("t2_mem_wen", 32'(mem_wen), 1); chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF); chk("t2_mem_wmask", 32'(mem_wmask), 32'hF);
        cyc(); smp(); chk("t2_early_resp", 32'(lsu_resp_valid), 0);
        cyc(); smp(); chk("t2_resp", 32'(lsu_resp_valid), 1);
        cyc(); smp(); chk("t2_pulse_end", 32'(lsu_resp_valid), 0);
        // simultaneous requests alternate, IFU first after reset
        cyc(); rst = 1;
        cyc(); rst = 0;
        ifu_req_valid = 1; lsu_req_valid = 1; ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_2000;
        g = 0; n = 0;
        while (g < 4 && n < 40) begin
            smp();
            if (ifu_req_ready || lsu_req_ready) begin
                chk($sformatf("t3_grant%0d", g), {30'd0, ifu_req_ready, lsu_req_ready}, g[0] ? 32'd1 : 32'd2);
                push(g[0], (g[0] ? lsu_addr : ifu_addr) ^ K, 0);
                g++;
            end
            n++;
            cyc();
        end
        chk("t3_grants", g, 4);
        ifu_req_valid = 0; lsu_req_valid = 0;
        repeat (4) cyc();
        // slave stalls ready, then reports an error
        stall = 5; fixed_en = 1; fixed_data = 32'h1234_5678; fixed_err = 1;
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0;
        push(1, 32'h1234_5678, 1);
        smp(); chk("t4_lsu_ready", 32'(lsu_req_ready), 1);
        cyc(); lsu_req_valid = 0; lsu_addr = 0;
        for (int i = 0; i < 6; i++) begin
            smp(); chk($sformatf("t4_stall_valid%0d", i), 32'(mem_req_valid), 1);
            chk($sformatf("t4_stall_addr%0d", i), mem_addr, 32'h8000_3000);
            cyc();
        end
        smp(); chk("t4_wait", 32'(mem_req_valid), 0);
        cyc(); smp(); chk("t4_resp", 32'(lsu_resp_valid), 1); chk("t4_err", 32'(lsu_resp_err), 1);
        cyc(); stall = 0; fixed_en = 0; fixed_err = 0;
        // hung slave, watchdog expires
        cyc(); hang = 1;
        ifu_req_valid = 1; ifu_addr = 32'h8000_4000;
        push(0, 32'h0, 1);
        smp(); chk("t5_ifu_ready", 32'(ifu_req_ready), 1);
        cyc(); ifu_req_valid = 0;
        for (int i = 0; i < 8; i++) begin
            smp(); chk($sformatf("t5_no_resp%0d", i), 32'(ifu_resp_valid), 0);
            chk($sformatf("t5_req_held%0d", i), 32'(mem_req_valid), 1);
            cyc();
        end
        smp(); chk("t5_timeout_resp", 32'(ifu_resp_valid), 1); chk("t5_timeout_err", 32'(ifu_resp_err), 1);
        chk("t5_timeout_rdata", ifu_rdata, 0); chk("t5_req_dropped", 32'(mem_req_valid), 0);
        stray = 1;
        cyc(); stray = 0;
        smp(); chk("t5_stray_ignored", 32'(mem_req_valid), 0);
        cyc(); smp(); chk("t5_no_stray_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 0);
        cyc(); hang = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_4004;
        push(0, 32'h8000_4004 ^ K, 0);
        smp(); chk("t5_fresh_ready", 32'(ifu_req_ready), 1);
        cyc(); ifu_req_valid = 0;
        cyc(); cyc(); smp(); chk("t5_fresh_resp", 32'(ifu_resp_valid), 1);
        cyc(); cyc();
        // reset while waiting for a response
        noresp = 1;
        lsu_req_valid = 1; lsu_addr = 32'h8000_5000;
        smp(); chk("t6_lsu_ready", 32'(lsu_req_ready), 1);
        cyc(); lsu_req_valid = 0;
        cyc(); smp(); chk("t6_in_wait", 32'(mem_req_valid), 0);
        cyc(); rst = 1;
        cyc(); rst = 0;
        smp(); chk_quiet("t6_after_reset");
        for (int i = 0; i < 10; i++) begin
            cyc(); smp(); chk($sformatf("t6_no_pulse%0d", i), 32'({lsu_resp_valid, mem_req_valid}), 0);
        end
        noresp = 0;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
